// File: rtl/c_pkg.sv
// Shared types and helpers for the c_join_sync completion-join block.
package c_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } c_state_e;

    // Widest input vector the popcount helper accepts; callers zero-extend.
    localparam int unsigned PC_MAX = 64;

    function automatic int unsigned popcount(input logic [PC_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PC_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/c_join_sync.sv
// Clocked N-of-M C-element join with hysteresis thresholds and a stuck-partial detector.
module c_join_sync
    import c_pkg::*;
#(
    parameter int IN_NUM      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HI_THR      = IN_NUM,
    parameter int LO_THR      = 0,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8,
    localparam int CW         = $clog2(IN_NUM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_NUM-1:0] in,
    input  logic              clear,
    output logic              out,
    output logic              rise,
    output logic              fall,
    output logic              stuck,
    output logic [CW-1:0]     cnt
);

    // A single input cannot be partially complete, so thresholds collapse to 1/0.
    localparam int unsigned HI_EFF = (IN_NUM == 1) ? 32'd1 : 32'(HI_THR);
    localparam int unsigned LO_EFF = (IN_NUM == 1) ? 32'd0 : 32'(LO_THR);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    if (IN_NUM < 1 || IN_NUM > int'(PC_MAX)) begin : g_bad_in_num
        $error("c_join_sync: IN_NUM out of range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("c_join_sync: SYNC_STAGES must be >= 2");
    end
    if (IN_NUM > 1 && (LO_THR < 0 || LO_THR >= HI_THR || HI_THR > IN_NUM)) begin : g_bad_thr
        $error("c_join_sync: need 0 <= LO_THR < HI_THR <= IN_NUM");
    end
    if (TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_to
        $error("c_join_sync: TIMEOUT must fit in 1..2**TO_W-1");
    end

    logic [IN_NUM-1:0] s;
    logic [PC_MAX-1:0] s_ext;
    int unsigned       pop;

    for (genvar i = 0; i < IN_NUM; i++) begin : g_sync
        sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (in[i]),
            .q_o   (s[i])
        );
    end

    assign s_ext = PC_MAX'(s);
    assign pop   = popcount(s_ext);

    c_state_e        state_q, state_d;
    logic            out_q, out_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            stuck_q, stuck_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            partial_q, stable_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOW: begin
                if (pop >= HI_EFF)      state_d = HIGH;
                else if (pop > LO_EFF)  state_d = RISING;
            end
            RISING: begin
                if (pop >= HI_EFF)      state_d = HIGH;
                else if (pop <= LO_EFF) state_d = LOW;
            end
            HIGH: begin
                if (pop <= LO_EFF)      state_d = LOW;
                else if (pop < HI_EFF)  state_d = FALLING;
            end
            FALLING: begin
                if (pop <= LO_EFF)      state_d = LOW;
                else if (pop >= HI_EFF) state_d = HIGH;
            end
            default: state_d = LOW;
        endcase

        partial_q = (state_q == RISING) || (state_q == FALLING);
        stable_d  = (state_d == LOW) || (state_d == HIGH);

        out_d  = (state_d == HIGH) || (state_d == FALLING);
        rise_d = (state_d == HIGH) && ((state_q == LOW) || (state_q == RISING));
        fall_d = (state_d == LOW) && ((state_q == HIGH) || (state_q == FALLING));
        cnt_d  = CW'(pop);

        // Counts cycles already spent in a partial state; the entry cycle reads 0.
        to_d = '0;
        if (!clear && !stable_d && partial_q) begin
            to_d = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
        end
        stuck_d = clear ? 1'b0 : (stuck_q || (to_d == TO_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            stuck_q <= 1'b0;
            to_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stuck_q <= stuck_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out   = out_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign stuck = stuck_q;
    assign cnt   = cnt_q;

endmodule

// File: tb/tb_c_join_sync.sv
// Directed scoreboard bench for c_join_sync: default 4-of-4 join (A) and 3/1-threshold join (B).
module tb_c_join_sync;

    localparam int S_OUT = 0, S_RISE = 1, S_FALL = 2, S_STUCK = 3, S_CNT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    logic       a_out, a_rise, a_fall, a_stuck;
    logic       b_out, b_rise, b_fall, b_stuck;
    logic [2:0] a_cnt, b_cnt;

    c_join_sync dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_a),
        .clear (clear),
        .out   (a_out),
        .rise  (a_rise),
        .fall  (a_fall),
        .stuck (a_stuck),
        .cnt   (a_cnt)
    );

    c_join_sync #(.HI_THR(3), .LO_THR(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_b),
        .clear (clear),
        .out   (b_out),
        .rise  (b_rise),
        .fall  (b_fall),
        .stuck (b_stuck),
        .cnt   (b_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string tag;
        int    at;
        int    dut;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input int dut, input int sig);
        logic [31:0] r;
        r = 'x;
        if (dut == 0) begin
            case (sig)
                S_OUT:   r = {31'd0, a_out};
                S_RISE:  r = {31'd0, a_rise};
                S_FALL:  r = {31'd0, a_fall};
                S_STUCK: r = {31'd0, a_stuck};
                default: r = {29'd0, a_cnt};
            endcase
        end else begin
            case (sig)
                S_OUT:   r = {31'd0, b_out};
                S_RISE:  r = {31'd0, b_rise};
                S_FALL:  r = {31'd0, b_fall};
                S_STUCK: r = {31'd0, b_stuck};
                default: r = {29'd0, b_cnt};
            endcase
        end
        return r;
    endfunction

    task automatic push(input string tag, input int dly, input int dut, input int sig, input int val);
        exp_t e;
        int   idx;
        e.tag = tag;
        e.at  = cyc + dly;
        e.dut = dut;
        e.sig = sig;
        e.val = val;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > e.at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic expect_all(input string tag, input int dly, input int dut,
                              input int o, input int r, input int f, input int s, input int c);
        push(tag, dly, dut, S_OUT, o);
        push(tag, dly, dut, S_RISE, r);
        push(tag, dly, dut, S_FALL, f);
        push(tag, dly, dut, S_STUCK, s);
        push(tag, dly, dut, S_CNT, c);
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    exp_t        e_chk;
    logic [31:0] obs_chk;
    logic [31:0] exp_chk;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e_chk   = sb.pop_front();
            obs_chk = observe(e_chk.dut, e_chk.sig);
            exp_chk = e_chk.val;
            checks++;
            assert (e_chk.at == cyc && obs_chk === exp_chk) else begin
                errors++;
                $error("FAIL %s: dut%0d sig%0d observed %0d expected %0d (cycle %0d, due %0d)",
                       e_chk.tag, e_chk.dut, e_chk.sig, obs_chk, exp_chk, cyc, e_chk.at);
            end
        end
    end

    initial begin
        // Reset state of both instances
        go(2);
        expect_all("reset_a", 0, 0, 0, 0, 0, 0, 0);
        expect_all("reset_b", 0, 1, 0, 0, 0, 0, 0);
        go(1);
        rst_n = 1'b1;
        go(1);

        // A: all inputs complete at once -> out and rise three edges later
        in_a = 4'hF;
        expect_all("a_rise_pre", 2, 0, 0, 0, 0, 0, 0);
        expect_all("a_rise", 3, 0, 1, 1, 0, 0, 4);
        expect_all("a_rise_hold", 4, 0, 1, 0, 0, 0, 4);
        go(6);

        // A: partial drop holds out high, then full drop falls
        in_a = 4'h7;
        push("a_partial_cnt", 3, 0, S_CNT, 3);
        for (int k = 3; k <= 12; k++) begin
            push("a_partial_out", k, 0, S_OUT, 1);
            push("a_partial_fall", k, 0, S_FALL, 0);
            push("a_partial_stuck", k, 0, S_STUCK, 0);
        end
        go(11);
        in_a = 4'h0;
        expect_all("a_fall", 3, 0, 0, 0, 1, 0, 0);
        expect_all("a_fall_hold", 4, 0, 0, 0, 0, 0, 0);
        go(6);

        // B: HI_THR=3 / LO_THR=1 hysteresis
        in_b = 4'h7;
        expect_all("b_rise", 3, 1, 1, 1, 0, 0, 3);
        go(6);
        in_b = 4'h3;
        expect_all("b_hold_hi", 3, 1, 1, 0, 0, 0, 2);
        go(6);
        in_b = 4'h1;
        expect_all("b_fall", 3, 1, 0, 0, 1, 0, 1);
        go(6);
        in_b = 4'h3;
        expect_all("b_hold_lo", 3, 1, 0, 0, 0, 0, 2);
        go(6);
        in_b = 4'h7;
        expect_all("b_rise_from_partial", 3, 1, 1, 1, 0, 0, 3);
        go(6);
        in_b = 4'h0;
        expect_all("b_fall_direct", 3, 1, 0, 0, 1, 0, 0);
        go(6);

        // A: reset pulse mid-HIGH, inputs stay complete
        in_a = 4'hF;
        expect_all("a_high_again", 3, 0, 1, 1, 0, 0, 4);
        go(6);
        rst_n = 1'b0;
        expect_all("a_midrst", 0, 0, 0, 0, 0, 0, 0);
        go(2);
        rst_n = 1'b1;
        expect_all("a_rel_pre", 2, 0, 0, 0, 0, 0, 0);
        expect_all("a_rel_rise", 3, 0, 1, 1, 0, 0, 4);
        expect_all("a_rel_hold", 4, 0, 1, 0, 0, 0, 4);
        go(6);
        in_a = 4'h0;
        expect_all("a_fall2", 3, 0, 0, 0, 1, 0, 0);
        go(6);

        // A: partial 0011 held -> stuck after TIMEOUT cycles in RISING
        in_a = 4'h3;
        expect_all("a_rising", 3, 0, 0, 0, 0, 0, 2);
        push("a_stuck_pre", 257, 0, S_STUCK, 0);
        push("a_stuck_set", 258, 0, S_STUCK, 1);
        push("a_stuck_out", 258, 0, S_OUT, 0);
        go(262);
        push("a_stuck_held", 0, 0, S_STUCK, 1);
        clear = 1'b1;
        go(1);
        clear = 1'b0;
        push("a_clear", 0, 0, S_STUCK, 0);
        push("a_clear_out", 0, 0, S_OUT, 0);

        // A: clear coincident with the stuck-setting edge
        go(254);
        clear = 1'b1;
        go(1);
        clear = 1'b0;
        push("a_clear_coinc", 0, 0, S_STUCK, 0);
        push("a_restart_pre", 254, 0, S_STUCK, 0);
        push("a_restart_set", 255, 0, S_STUCK, 1);
        go(256);

        // A: leaving the partial state keeps stuck sticky; only clear drops it
        in_a = 4'h0;
        expect_all("a_abort_low", 3, 0, 0, 0, 0, 1, 0);
        go(5);
        clear = 1'b1;
        go(1);
        clear = 1'b0;
        push("a_final_clear", 0, 0, S_STUCK, 0);
        go(5);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
